// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window scheduler.
//   state_t : controller states
//   cnt_w   : counter width helper, never returns 0
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      FILL   = 3'd2,
      STREAM = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Width needed to hold values 0..n-1; at least one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_window_sched_if.sv
// Column handshake, FIFO control and PE-array window bus of the scheduler.
//   master : controller side (drives in_ready, FIFO strobes, window outputs)
//   slave  : environment side (column source, FIFO flags, PE array)
interface conv_window_sched_if
   import conv_pkg::*;
#(
   parameter int unsigned IMG_W = 16
) ();

   localparam int unsigned COL_W = cnt_w(IMG_W);

   logic             in_valid;
   logic             in_ready;
   logic             fifo_wr_en;
   logic             fifo_rd_en;
   logic             fifo_clear;
   logic             fifo_empty;
   logic             pe_stall;
   logic             win_valid;
   logic [COL_W-1:0] col_idx;
   logic             row_done;

   modport master (
      input  in_valid, fifo_empty, pe_stall,
      output in_ready, fifo_wr_en, fifo_rd_en, fifo_clear,
             win_valid, col_idx, row_done
   );

   modport slave (
      output in_valid, fifo_empty, pe_stall,
      input  in_ready, fifo_wr_en, fifo_rd_en, fifo_clear,
             win_valid, col_idx, row_done
   );

endinterface

// File: rtl/conv_window_sched.sv
// Sequences the row FIFO feeding the convolution PE array: clears it at frame
// start, fills it to KSIZE columns, then streams one window column per cycle,
// counting columns per band and bands per frame. Occupancy is tracked locally.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a frame (sampled in IDLE only)
//   bus         : column handshake, FIFO strobes/flag, window outputs
//   frame_done  : one-cycle pulse at end of frame
//   busy        : controller not idle
//   err         : sticky, FIFO read issued while FIFO reported empty
module conv_window_sched
   import conv_pkg::*;
#(
   parameter int unsigned RES   = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned KSIZE = 3,
   parameter int unsigned IMG_W = 16,
   parameter int unsigned ROWS  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   conv_window_sched_if.master bus,
   output logic                frame_done,
   output logic                busy,
   output logic                err
);

   localparam int unsigned OCC_W = cnt_w(DEPTH + 1);
   localparam int unsigned CNT_W = cnt_w(IMG_W + 1);
   localparam int unsigned ROW_W = cnt_w(ROWS);
   localparam int unsigned COL_W = cnt_w(IMG_W);

   localparam logic [OCC_W-1:0] OCC_DEPTH = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] OCC_KSIZE = OCC_W'(KSIZE);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

   // Reject parameter sets the fill/stream sequencing cannot honour.
   if (DEPTH < KSIZE || IMG_W < KSIZE || KSIZE == 0 || ROWS == 0 || RES == 0) begin : g_cfg_err
      $error("conv_window_sched: invalid parameter set");
   end

   state_t             state_q, state_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic [CNT_W-1:0]   wr_cnt_q;
   logic [CNT_W-1:0]   rd_cnt_q;
   logic [ROW_W-1:0]   row_q;

   logic               fifo_clear_q;
   logic               win_valid_q;
   logic [COL_W-1:0]   col_idx_q;
   logic               row_done_q;
   logic               frame_done_q;
   logic               busy_q;
   logic               err_q;

   logic               in_ready_c;
   logic               wr_en_c;
   logic               rd_en_c;
   logic               last_rd_c;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, handshake strobes and occupancy update.
   always_comb begin
      state_d    = state_q;
      in_ready_c = 1'b0;
      wr_en_c    = 1'b0;
      rd_en_c    = 1'b0;
      last_rd_c  = 1'b0;
      occ_d      = occ_q;

      in_ready_c = ((state_q == FILL) || (state_q == STREAM)) &&
                   (occ_q < OCC_DEPTH) && (wr_cnt_q < CNT_MAX);
      wr_en_c    = bus.in_valid && in_ready_c;
      rd_en_c    = (state_q == STREAM) && (occ_q != '0) &&
                   !bus.pe_stall && (rd_cnt_q < CNT_MAX);
      last_rd_c  = rd_en_c && (rd_cnt_q == CNT_LAST);

      // Simultaneous write and read leaves occupancy unchanged.
      unique case ({wr_en_c, rd_en_c})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase

      unique case (state_q)
         IDLE:    if (start) state_d = CLR;
         CLR:     state_d = FILL;
         FILL:    if (occ_d >= OCC_KSIZE) state_d = STREAM;
         STREAM: begin
            if (last_rd_c) begin
               state_d = (row_q == ROW_LAST) ? DONE : FILL;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q        <= '0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         row_q        <= '0;
         fifo_clear_q <= 1'b0;
         win_valid_q  <= 1'b0;
         col_idx_q    <= '0;
         row_done_q   <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         fifo_clear_q <= (state_q == IDLE) && start;
         frame_done_q <= (state_q == DONE);
         busy_q       <= (state_d != IDLE);
         win_valid_q  <= rd_en_c;
         row_done_q   <= last_rd_c;
         err_q        <= err_q | (rd_en_c & bus.fifo_empty);
         if (rd_en_c) begin
            col_idx_q <= COL_W'(rd_cnt_q);
         end

         if (state_q == CLR) begin
            occ_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            row_q    <= '0;
         end else begin
            occ_q <= occ_d;
            // Band end restarts the per-band column counters.
            if (last_rd_c) begin
               wr_cnt_q <= '0;
               rd_cnt_q <= '0;
               if (row_q != ROW_LAST) begin
                  row_q <= row_q + ROW_W'(1);
               end
            end else begin
               if (wr_en_c) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
               if (rd_en_c) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.fifo_wr_en = wr_en_c;
   assign bus.fifo_rd_en = rd_en_c;
   assign bus.fifo_clear = fifo_clear_q;
   assign bus.win_valid  = win_valid_q;
   assign bus.col_idx    = col_idx_q;
   assign bus.row_done   = row_done_q;
   assign frame_done     = frame_done_q;
   assign busy           = busy_q;
   assign err            = err_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// Self-checking bench for conv_window_sched: directed scenarios plus random
// valid/stall frames, compared each cycle against a queue-based frame model.
module tb_conv_window_sched;

   localparam int unsigned RES   = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned KSIZE = 3;
   localparam int unsigned IMG_W = 5;
   localparam int unsigned ROWS  = 2;

   logic clk;
   logic rst;
   logic start;
   logic frame_done;
   logic busy;
   logic err;

   conv_window_sched_if #(.IMG_W(IMG_W)) bus ();

   conv_window_sched #(
      .RES   (RES),
      .DEPTH (DEPTH),
      .KSIZE (KSIZE),
      .IMG_W (IMG_W),
      .ROWS  (ROWS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .frame_done (frame_done),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Frame model: FIFO contents are the column numbers written this band.
   typedef enum int {M_IDLE, M_CLR, M_FILL, M_STREAM, M_DONE} mmode_t;
   mmode_t mode;
   int     q[$];
   int     nwr, nrd, band;
   bit     e_fifo_clear, e_win_valid, e_row_done, e_frame_done, e_busy, e_err;
   int     e_col_idx;

   bit obs_rd, obs_win, obs_rowdone, obs_fdone;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mode = M_IDLE;
      q.delete();
      nwr = 0; nrd = 0; band = 0;
      e_fifo_clear = 0; e_win_valid = 0; e_row_done = 0;
      e_frame_done = 0; e_busy = 0; e_err = 0; e_col_idx = 0;
   endtask

   // One clock: drive inputs, check all outputs, advance the model.
   task automatic cycle(input bit v, input bit s, input bit st, input bit e, input bit r);
      bit m_ir, m_wr, m_rd;
      int col;
      rst = r; start = st;
      bus.in_valid = v; bus.pe_stall = s; bus.fifo_empty = e;
      #1;
      m_ir = ((mode == M_FILL) || (mode == M_STREAM)) && (q.size() < DEPTH) && (nwr < IMG_W);
      m_wr = v && m_ir;
      m_rd = (mode == M_STREAM) && (q.size() > 0) && !s && (nrd < IMG_W);
      chk("in_ready",   bus.in_ready,   m_ir);
      chk("fifo_wr_en", bus.fifo_wr_en, m_wr);
      chk("fifo_rd_en", bus.fifo_rd_en, m_rd);
      chk("fifo_clear", bus.fifo_clear, e_fifo_clear);
      chk("win_valid",  bus.win_valid,  e_win_valid);
      if (e_win_valid) chk("col_idx", bus.col_idx, e_col_idx);
      chk("row_done",   bus.row_done,   e_row_done);
      chk("frame_done", frame_done,     e_frame_done);
      chk("busy",       busy,           e_busy);
      chk("err",        err,            e_err);
      obs_rd = bus.fifo_rd_en; obs_win = bus.win_valid;
      obs_rowdone = bus.row_done; obs_fdone = frame_done;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         e_fifo_clear = (mode == M_IDLE) && st;
         e_frame_done = (mode == M_DONE);
         e_err        = e_err || (m_rd && e);
         e_win_valid  = m_rd;
         e_row_done   = 0;
         col          = -1;
         if (m_rd) begin
            col = q.pop_front();
            nrd++;
            e_col_idx  = col;
            e_row_done = (col == IMG_W - 1);
         end
         if (m_wr) begin
            q.push_back(nwr);
            nwr++;
         end
         case (mode)
            M_IDLE: if (st) mode = M_CLR;
            M_CLR: begin
               q.delete(); nwr = 0; nrd = 0; band = 0;
               mode = M_FILL;
            end
            M_FILL: if (q.size() >= KSIZE) mode = M_STREAM;
            M_STREAM: begin
               if (col == IMG_W - 1) begin
                  if (band == ROWS - 1) begin
                     mode = M_DONE;
                  end else begin
                     band++; nwr = 0; nrd = 0;
                     mode = M_FILL;
                  end
               end
            end
            default: mode = M_IDLE;
         endcase
         e_busy = (mode != M_IDLE);
      end
      @(negedge clk);
   endtask

   // Runs one frame (start at k=0) until frame_done or a cycle budget.
   task automatic run_frame(input int kind, output int first_rd, output int fdone,
                            output int wins, output int rds);
      bit v, s, st, e, ended;
      first_rd = -1; fdone = -1; wins = 0; rds = 0; ended = 0;
      for (int k = 0; k < 300 && !ended; k++) begin
         v = 1; s = 0; st = (k == 0); e = (q.size() == 0);
         case (kind)
            1: v = !(k >= 3 && k <= 6);
            2: s = (k >= 7 && k <= 9);
            3: if (k == 6) st = 1;
            4: begin
               v = ($urandom_range(0, 9) < 7);
               s = ($urandom_range(0, 9) < 3);
               if (k > 0 && k < 10) st = ($urandom_range(0, 3) == 0);
            end
            5: if (k == 6) e = 1;
            default: ;
         endcase
         cycle(v, s, st, e, 0);
         if (obs_rd && first_rd < 0) first_rd = k;
         if (obs_win) wins++;
         if (obs_rowdone) rds++;
         if (obs_fdone) begin
            fdone = k;
            ended = 1;
         end
      end
      if (!ended) chk("frame_timeout", 0, 1);
   endtask

   int first_rd, fdone, wins, rds;

   initial begin
      rst = 1; start = 0;
      bus.in_valid = 0; bus.pe_stall = 0; bus.fifo_empty = 1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 0);

      // Nominal frame: clear at 1, first read at 5, frame_done at 19.
      run_frame(0, first_rd, fdone, wins, rds);
      chk("nominal_first_rd", first_rd, 5);
      chk("nominal_frame_done_cycle", fdone, 19);
      chk("nominal_wins", wins, IMG_W * ROWS);
      chk("nominal_row_done", rds, ROWS);
      cycle(0, 0, 0, 1, 0);

      // Input gap during fill.
      run_frame(1, first_rd, fdone, wins, rds);
      chk("gap_wins", wins, IMG_W * ROWS);
      chk("gap_row_done", rds, ROWS);
      chk("gap_err", err, 0);
      cycle(0, 0, 0, 1, 0);

      // PE stall mid-band.
      run_frame(2, first_rd, fdone, wins, rds);
      chk("stall_wins", wins, IMG_W * ROWS);
      chk("stall_row_done", rds, ROWS);
      cycle(0, 0, 0, 1, 0);

      // start during STREAM is ignored.
      run_frame(3, first_rd, fdone, wins, rds);
      chk("restart_first_rd", first_rd, 5);
      chk("restart_wins", wins, IMG_W * ROWS);
      cycle(0, 0, 0, 1, 0);

      // Reset mid-band, then a clean frame.
      for (int k = 0; k < 8; k++) cycle(1, 0, (k == 0), (q.size() == 0), 0);
      cycle(1, 0, 0, (q.size() == 0), 1);
      chk("rst_busy", busy, 0);
      chk("rst_win_valid", bus.win_valid, 0);
      cycle(0, 0, 0, 1, 0);
      run_frame(0, first_rd, fdone, wins, rds);
      chk("post_rst_first_rd", first_rd, 5);
      chk("post_rst_wins", wins, IMG_W * ROWS);
      cycle(0, 0, 0, 1, 0);

      // Read while the FIFO claims empty sets a sticky error.
      run_frame(5, first_rd, fdone, wins, rds);
      cycle(0, 0, 0, 1, 0);
      chk("err_sticky", err, 1);
      cycle(0, 0, 0, 1, 1);
      chk("err_cleared", err, 0);
      cycle(0, 0, 0, 1, 0);

      // Random input/stall frames.
      for (int f = 0; f < 6; f++) begin
         run_frame(4, first_rd, fdone, wins, rds);
         chk("rand_wins", wins, IMG_W * ROWS);
         chk("rand_row_done", rds, ROWS);
         cycle(0, 0, 0, 1, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Controller that sequences the multi-lane row FIFO feeding the convolution PE array. It accepts column vectors from the line-buffer front end and fills the FIFO to a kernel-width threshold. It then streams one window column per cycle to the PE array and counts columns and row bands. The FIFO is cleared at frame start, and row-band and frame completion are signalled. It sits between the input column source, the FIFO instance and the PE array, and tracks FIFO occupancy itself rather than trusting the FIFO's flags.

## Interface
- RES, 8: pixel width (passed through for sizing only; no data path in this block)
- DEPTH, 4: FIFO depth in column entries; DEPTH >= KSIZE
- KSIZE, 3: kernel width; columns buffered before streaming starts
- IMG_W, 16: columns per row band; IMG_W >= KSIZE
- ROWS, 4: row bands per frame
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  upstream column available
- in_ready  out  1  controller accepts the column (combinational)
- fifo_wr_en  out  1  = in_valid & in_ready (combinational)
- fifo_rd_en  out  1  FIFO read strobe (combinational from state/counters)
- fifo_clear  out  1  one-cycle FIFO clear (registered)
- fifo_empty  in  1  FIFO flag, used only for the error check
- pe_stall  in  1  PE array cannot take a column this cycle
- win_valid  out  1  FIFO data_out is valid this cycle (registered)
- col_idx  out  $clog2(IMG_W)  column index of the current win_valid
- row_done  out  1  pulse with the last win_valid of a band
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  state != IDLE
- err  out  1  sticky: fifo_rd_en issued while fifo_empty

## Operation
- States:
  - IDLE: start=1 -> CLR.
  - CLR: fifo_clear=1 for exactly 1 cycle. Counters occ, wr_cnt, rd_cnt and row_idx are zeroed. Next state is FILL.
  - FILL: accepts writes only. When occ reaches KSIZE (counting a write in the current cycle), go to STREAM.
  - STREAM: writes and reads may occur in the same cycle.
    - After the read with rd_cnt == IMG_W-1: if row_idx == ROWS-1, go to DONE. Otherwise row_idx++, wr_cnt and rd_cnt reset to 0, and go to FILL.
  - DONE: frame_done=1 for 1 cycle, then IDLE.
- in_ready = (state is FILL or STREAM) & (occ < DEPTH) & (wr_cnt < IMG_W).
- fifo_rd_en = (state == STREAM) & (occ > 0) & !pe_stall & (rd_cnt < IMG_W).
- Occupancy update:
  - Write only: occ+1.
  - Read only: occ-1.
  - Both in the same cycle: occ unchanged.
  - occ width is $clog2(DEPTH+1) and never exceeds DEPTH.
- At the FILL entry of a later band, occ carries whatever remains. By construction this is 0, because reads equal writes equal IMG_W per band.
- win_valid and col_idx are fifo_rd_en and rd_cnt delayed by one cycle, matching the FIFO's registered output. The PE array must capture on win_valid; there is no hold.
- err is set when fifo_rd_en & fifo_empty. It is cleared only by rst.
- start is ignored outside IDLE.
- Reset values: all registered outputs are 0 (fifo_clear, win_valid, col_idx, row_done, frame_done, err). State is IDLE and all counters are 0.
- Reset mid-frame: the controller returns to IDLE next cycle, and any pending win_valid is dropped. The FIFO is cleared by the next start's CLR.

## Timing
- From start in cycle t: fifo_clear is high in t+1 and FILL begins in t+2.
- With in_valid held high, the first fifo_rd_en occurs in cycle t+2+KSIZE and the first win_valid in the cycle after.
- Steady-state throughput is 1 column/cycle when in_valid=1 and pe_stall=0.
- pe_stall gates fifo_rd_en in the same cycle. A win_valid already scheduled from the previous cycle's read still fires.
- row_done coincides with win_valid for col_idx == IMG_W-1.
- frame_done fires the cycle after the final row_done.

## Structure
- Shared package conv_pkg holds the state enum (IDLE, CLR, FILL, STREAM, DONE) and a width helper for the counters.
- Single module; no sub-module. The occupancy counter is inline, because its increment/decrement rule is specific to this controller.

## Test plan
- IMG_W=5, ROWS=2, DEPTH=4, KSIZE=3, in_valid always high, no stall, start at cycle 0 -> fifo_clear at 1; first rd_en at 5; win_valid at 6..10 with col_idx 0..4; row_done at 10; second band ends with row_done; frame_done the following cycle; busy drops after it.
- Same configuration with in_valid low for cycles 3–6 -> occ never goes negative; FILL waits until 3 columns are accepted; win_valid count per band is still exactly 5; err stays 0.
- pe_stall high for 3 cycles mid-band with continuous input -> in_ready drops when occ=4; no write is lost; win_valid resumes with the next col_idx in sequence.
- start pulsed during STREAM -> ignored: no fifo_clear, and counters are unaffected.
- rst asserted mid-band -> next cycle state=IDLE, all outputs 0 and busy=0. A new start produces a clean frame with col_idx starting at 0.
- Force fifo_empty=1 while a read is issued -> err=1 and stays set until rst.
